// File: rtl/ram8.sv
// ram8: 8-word x WIDTH-bit register memory (Hack RAM8).
// Rev 1.0 - initial release.
`default_nettype none

module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  localparam int DEPTH = 8;

  logic [DEPTH-1:0]            load_sel;
  logic [DEPTH-1:0][WIDTH-1:0] words;

  // dmux8way: the single load strobe goes to exactly one word register
  always_comb begin
    load_sel = '0;
    if (load) begin
      load_sel[address] = 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [WIDTH-1:0] q;

      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (load_sel[i]) begin
          q <= in;
        end
      end

      assign words[i] = q;
    end
  endgenerate

  // Read is purely combinational: no bypass, so a write shows up after the edge
  assign out = words[address];

endmodule

`default_nettype wire
